// File: rtl/scan_demux_if.sv
// Pin-side bundle for scan_demux: raw active-low pull-up inputs in, registered one-hot outputs out.
interface scan_demux_if #(
  parameter int SEL_W = 2
);
  localparam int OUT_N = 2**SEL_W;

  logic [SEL_W-1:0] sel_n;
  logic             din_n;
  logic             mode_n;
  logic [OUT_N-1:0] out;
  logic [SEL_W-1:0] ch;
  logic             chg;

  modport master (output sel_n, din_n, mode_n, input out, ch, chg);
  modport slave  (input sel_n, din_n, mode_n, output out, ch, chg);
endinterface

// File: rtl/scan_demux.sv
// 1-to-2^SEL_W demux with synchronised/debounced pull-up inputs and an auto-scan mode.
// Define SCAN_DEMUX_DEBOUNCE_EN to include the per-bit debounce counters.
module scan_demux #(
  parameter int SEL_W      = 2,
  parameter int DEB_CYCLES = 16,
  parameter int SCAN_DIV   = 16000000
) (
  input logic        CLK,
  input logic        RST_N,
  scan_demux_if.slave pins
);
  localparam int OUT_N = 2**SEL_W;
  localparam int NB    = SEL_W + 2;  // {mode, din, sel}
  localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [0:0] ST_MANUAL = 1'b0;
  localparam logic [0:0] ST_SCAN   = 1'b1;

  // Synchroniser holds pin levels, so reset to 1 means "released"
  logic [NB-1:0] s1_q, s2_q, syn, acc;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= {pins.mode_n, pins.din_n, pins.sel_n};
      s2_q <= s1_q;
    end
  end

  assign syn = ~s2_q;

`ifdef SCAN_DEMUX_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [NB-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NB-1:0]         acc_q, acc_d;

  // A bit differing from its accepted value can only flip back to it, so
  // equality alone covers "changed again" for the counter clear.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    for (int b = 0; b < NB; b++) begin
      if (syn[b] == acc_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CW'(DEB_CYCLES - 1)) begin
        acc_d[b] = syn[b];
        cnt_d[b] = '0;
      end else begin
        cnt_d[b] = cnt_q[b] + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;
`else
  assign acc = syn;
`endif

  logic [SEL_W-1:0] sel_a;
  logic             din_a, mode_a;

  assign sel_a  = acc[SEL_W-1:0];
  assign din_a  = acc[SEL_W];
  assign mode_a = acc[SEL_W+1];

  logic [0:0]       st_q, st_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [PW-1:0]    psc_q, psc_d;
  logic [OUT_N-1:0] out_q;
  logic             chg_q;

  // In SCAN, ch_q itself is the scan counter; mode exit beats a due step.
  always_comb begin
    st_d  = st_q;
    ch_d  = ch_q;
    psc_d = psc_q;
    case (st_q)
      ST_MANUAL: begin
        if (mode_a) begin
          st_d  = ST_SCAN;
          psc_d = '0;
        end else begin
          ch_d = sel_a;
        end
      end
      default: begin
        if (!mode_a) begin
          st_d  = ST_MANUAL;
          ch_d  = sel_a;
          psc_d = '0;
        end else if (psc_q == PW'(SCAN_DIV - 1)) begin
          psc_d = '0;
          ch_d  = ch_q + SEL_W'(1);
        end else begin
          psc_d = psc_q + PW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      st_q  <= ST_MANUAL;
      ch_q  <= '0;
      psc_q <= '0;
      out_q <= '0;
      chg_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      ch_q  <= ch_d;
      psc_q <= psc_d;
      out_q <= din_a ? (OUT_N'(1) << ch_q) : '0;
      chg_q <= (ch_d != ch_q);
    end
  end

  assign pins.out = out_q;
  assign pins.ch  = ch_q;
  assign pins.chg = chg_q;
endmodule

// File: tb/tb_scan_demux.sv
// Randomised + directed bench for scan_demux against a window/arithmetic reference model.
module tb_scan_demux;
  localparam int SEL_W = 2;
  localparam int OUT_N = 4;
  localparam int DEB   = 4;
  localparam int DIV   = 8;
`ifdef SCAN_DEMUX_DEBOUNCE_EN
  localparam int DEB_EFF = DEB;
`else
  localparam int DEB_EFF = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scan_demux_if #(.SEL_W(SEL_W)) pins ();

  scan_demux #(.SEL_W(SEL_W), .DEB_CYCLES(DEB), .SCAN_DIV(DIV)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .pins (pins)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(string nm, int act, int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: accepted bit flips once the synchronised stream has shown the
  // opposite value for DEB_EFF consecutive cycles; scan position is entry index plus
  // elapsed cycles divided by the scan period.
  logic [3:0] hist [0:7];  // active-high {mode, din, sel}, [0] = newest pin sample
  logic [3:0] m_acc, nacc;
  logic [3:0] m_out;
  bit         m_scan, m_chg, stable;
  bit         mvalid = 1'b0;
  int         m_ch, m_base, m_tent, nch;
  int         cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) hist[i] = 4'b0;
      m_acc = 4'b0; m_scan = 0; m_ch = 0; m_out = 4'b0; m_chg = 0;
      mvalid = 1'b1;
    end else begin
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = ~{pins.mode_n, pins.din_n, pins.sel_n};
      if (!m_scan) begin
        if (m_acc[3]) begin
          m_scan = 1; m_tent = cyc; m_base = m_ch; nch = m_ch;
        end else begin
          nch = int'(m_acc[1:0]);
        end
      end else if (!m_acc[3]) begin
        m_scan = 0; nch = int'(m_acc[1:0]);
      end else begin
        nch = (m_base + (cyc - m_tent) / DIV) % OUT_N;
      end
      m_out = m_acc[2] ? 4'(1 << m_ch) : 4'b0;
      m_chg = (nch != m_ch);
      m_ch  = nch;
      if (DEB_EFF == 0) begin
        nacc = hist[1];
      end else begin
        nacc = m_acc;
        for (int b = 0; b < 4; b++) begin
          stable = 1;
          for (int k = 2; k <= DEB_EFF + 1; k++)
            if (hist[k][b] == m_acc[b]) stable = 0;
          if (stable) nacc[b] = ~m_acc[b];
        end
      end
      m_acc = nacc;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("out", int'(pins.out), int'(m_out));
      chk("ch",  int'(pins.ch),  m_ch);
      chk("chg", int'(pins.chg), int'(m_chg));
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until chg; 60 means the bound expired.
  task automatic wait_chg(output int n);
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (pins.chg) break;
      tick(1);
    end
  endtask

  int n, gl, lat;

  initial begin
    pins.sel_n = 2'b11; pins.din_n = 1'b1; pins.mode_n = 1'b1;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("rst_out", int'(pins.out), 0);
      chk("rst_ch",  int'(pins.ch), 0);
      chk("rst_chg", int'(pins.chg), 0);
      tick(1);
    end

    // Manual select of channel 2 with data asserted
    pins.din_n = 1'b0; pins.sel_n = 2'b01;
    tick(3 + DEB_EFF);
    @(negedge clk);
    chk("sel_ch", int'(pins.ch), 2);
    chk("sel_chg", int'(pins.chg), 1);
    tick(1);
    @(negedge clk);
    chk("sel_out", int'(pins.out), 4);
    chk("sel_chg_once", int'(pins.chg), 0);
    pins.din_n = 1'b1;
    tick(4 + DEB_EFF);
    @(negedge clk);
    chk("din_off_out", int'(pins.out), 0);
    chk("din_off_ch", int'(pins.ch), 2);

    // 3-cycle glitch on sel_n[0]
    tick(1);
    pins.sel_n = 2'b00; gl = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      gl += int'(pins.chg);
      tick(1);
      if (i == 2) pins.sel_n = 2'b01;
    end
    chk("glitch_chg_cnt", gl, (DEB_EFF > 0) ? 0 : 2);
    chk("glitch_ch", int'(pins.ch), 2);
    pins.sel_n = 2'b00;
    tick(3 + DEB_EFF);
    @(negedge clk);
    chk("stable_ch", int'(pins.ch), 3);
    chk("stable_chg", int'(pins.chg), 1);

    // Enter scan from ch=3
    tick(1);
    pins.din_n = 1'b0;
    tick(6);
    pins.mode_n = 1'b0;
    wait_chg(n);
    chk("scan_first_step", n, 11 + DEB_EFF);
    chk("scan_ch0", int'(pins.ch), 0);
    tick(1);
    pins.sel_n = 2'b10;  // tracked but ignored while scanning
    wait_chg(n);
    chk("scan_period1", n, 7);
    chk("scan_ch1", int'(pins.ch), 1);
    tick(1);
    wait_chg(n);
    chk("scan_period2", n, 7);
    chk("scan_ch2", int'(pins.ch), 2);

    // Leave scan on the same edge a step is due
    tick(5 - DEB_EFF);
    pins.mode_n = 1'b1;
    tick(3 + DEB_EFF);
    @(negedge clk);
    chk("manual_ret_ch", int'(pins.ch), 1);
    chk("manual_ret_chg", int'(pins.chg), 1);
    tick(1);
    @(negedge clk);
    chk("manual_hold_ch", int'(pins.ch), 1);

    // Reset pulse during scan, then full-latency check
    tick(1);
    pins.mode_n = 1'b0;
    tick(20);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out", int'(pins.out), 0);
    chk("midrst_ch", int'(pins.ch), 0);
    chk("midrst_chg", int'(pins.chg), 0);
    tick(1);
    pins.mode_n = 1'b1; pins.din_n = 1'b0; pins.sel_n = 2'b11;
    tick(12 + DEB_EFF);
    pins.sel_n = 2'b01;
    for (lat = 0; lat < 40; lat++) begin
      @(negedge clk);
      if (pins.out == 4'b0100) break;
      tick(1);
    end
    chk("pin_to_out_lat", lat, 4 + DEB_EFF);

    // Random segments with occasional reset pulses
    tick(1);
    repeat (400) begin
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end
      pins.sel_n = 2'($urandom);
      pins.din_n = 1'($urandom);
      if ($urandom_range(0, 3) == 0) pins.mode_n = ~pins.mode_n;
      tick($urandom_range(1, 12));
    end

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/scan_demux.md
# scan_demux

Parametrised 1-to-2^SEL_W demultiplexer/decoder for the pin-level board tops, with synchronised and debounced active-low pull-up inputs and a registered one-hot output. Besides manual channel selection it has an auto-scan mode that steps through the channels on a programmable period. It sits between the raw board pins (buttons/switches) and the LED/output pins.

## Interface
- SEL_W, 2: select width; OUT_N = 2**SEL_W outputs; legal range 1..5.
- DEB_CYCLES, 16: consecutive stable cycles required to accept an input change; must be ≥1.
- SCAN_DIV, 16000000: clock cycles per scan step (1 Hz at 16 MHz); must be ≥2.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  synchronous reset, active-low.
- sel_n  in  SEL_W  raw channel select from pull-up pins, active-low.
- din_n  in  1  raw data input, active-low.
- mode_n  in  1  raw mode pin, active-low; asserted (0) selects SCAN.
- out  out  OUT_N  registered demux output; only the active channel may be 1.
- ch  out  SEL_W  active channel index.
- chg  out  1  one-cycle pulse when ch changes.

## Operation
- Every raw input passes a 2-FF synchroniser. Synchroniser flops reset to 1 (pin released). The value is then inverted to active-high: sel, din, mode.
- Debounce, per bit: a counter, ceil(log2(DEB_CYCLES+1)) bits, is cleared whenever the synchronised bit equals the accepted bit, or the bit changes again. The accepted bit takes the new value when the counter hits DEB_CYCLES. Accepted values reset to 0.
- FSM, 2 states; reset state is MANUAL:
  - MANUAL: ch follows the accepted sel. Go to SCAN when accepted mode = 1.
  - SCAN: ch is driven by the scan counter. Go to MANUAL when accepted mode = 0.
- Entering SCAN: scan counter loads the current ch and the prescaler clears to 0, so there is no jump.
- Entering MANUAL: ch loads the accepted sel on the same edge as the state change.
- Prescaler (in SCAN) counts 0..SCAN_DIV-1. On reaching SCAN_DIV-1 it returns to 0 and ch increments modulo OUT_N (OUT_N-1 wraps to 0).
- out is registered: out[i] = din when i == ch, otherwise 0. With din held 1 the block behaves as a decoder.
- chg = 1 for exactly one cycle on the cycle ch takes a new value. It is not asserted for din-only changes or when a reload yields the same index.

## Timing
- Reset values: out = 0, ch = 0, chg = 0, state MANUAL, prescaler 0, all debounce counters 0.
- Raw pin edge to accepted value: 2 + DEB_CYCLES cycles, provided the pin is stable for the whole window.
- ch and chg update 1 cycle after acceptance; out updates 1 cycle after ch/din.
- Pin to out latency: 2 + DEB_CYCLES + 2 cycles.
- A glitch shorter than DEB_CYCLES cycles produces no change on any output.
- Scan steps occur exactly every SCAN_DIV cycles while in SCAN.
- Mode change and a scan step on the same cycle: the mode change wins and the prescaler is discarded.
- sel changes during SCAN are tracked by the debouncer but do not affect ch until MANUAL is re-entered.
- RST_N low mid-operation: all state returns to the reset values on that edge, regardless of mode or counter values. The first output after release follows the full latency.

## Configuration
- SCAN_DEMUX_DEBOUNCE_EN defined: debounce counters are present as described.
- Not defined: the debounce logic is removed. Accepted value = synchronised value, effectively DEB_CYCLES = 0, and pin to out latency is 4 cycles.
- The DEB_CYCLES parameter is ignored when the macro is not defined.

## Test plan
All scenarios use SEL_W=2, DEB_CYCLES=4, SCAN_DIV=8, macro defined unless stated.
- Reset, then all pins high (released) -> out=4'b0000, ch=0, chg=0 on every cycle.
- din_n=0, sel_n driven to 2'b01 (sel=2) and held -> ch=2 and chg pulse 7 cycles after the edge; out=4'b0100 one cycle later; din_n=1 -> out=0 with no chg.
- 3-cycle low glitch on sel_n[0] -> ch, out and chg unchanged; a 4-cycle stable low is accepted.
- In MANUAL with ch=3 and din=1, mode_n=0 -> SCAN entered; ch goes 3→0 after 8 cycles, then 1, 2, with a chg pulse each step and out one-hot following.
- Mode returns to MANUAL on the same cycle as a due scan step -> ch = accepted sel, no extra increment.
- RST_N low for 1 cycle during SCAN -> out=0, ch=0, state MANUAL next cycle. Repeat with the macro undefined: sel edge to out in 4 cycles.
